l15_port_arbiter: RTL and testbench

L15_PORT_ARBITER -- requirements
Module: l15_port_arbiter

---
 rtl/core_pkg.sv | 25 ++
 rtl/l15_req_mux.sv | 45 ++++
 rtl/l15_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_l15_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the L1.5 port arbiter: FSM states, grant owner and the
// request bundle carried from a requester to the L1.5.
package core_pkg;

  localparam int unsigned STREAK_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FE,
    OWN_MEM
  } owner_t;

  typedef struct packed {
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [31:0] address;
    logic [31:0] data;
  } l15_req_t;

endpackage

// File: rtl/l15_req_mux.sv
// 2:1 request select: mem has priority, fetch wins once mem has taken
// MEM_STREAK_MAX consecutive grants while fetch was waiting.
module l15_req_mux
  import core_pkg::*;
#(
  parameter int unsigned MEM_STREAK_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_grant_en,
  input  logic     i_fe_val,
  input  logic     i_mem_val,
  input  l15_req_t i_fe_req,
  input  l15_req_t i_mem_req,
  output logic     o_grant,
  output owner_t   o_owner,
  output l15_req_t o_req
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MEM_STREAK_MAX);

  logic [STREAK_W-1:0] r_streak;
  logic                w_fe_wins;

  always_comb begin
    w_fe_wins = i_fe_val && (!i_mem_val || (r_streak == STREAK_MAX));
    o_grant   = i_grant_en && (i_fe_val || i_mem_val);
    o_owner   = w_fe_wins ? OWN_FE : OWN_MEM;
    o_req     = w_fe_wins ? i_fe_req : i_mem_req;
  end

  // Streak only counts mem grants that actually made fetch wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (o_grant) begin
      if (w_fe_wins) begin
        r_streak <= '0;
      end else if (i_fe_val && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l15_port_arbiter.sv
// Shares one L1.5 request port between the fetch and memory stages; one
// transaction outstanding at a time, response routed back to the owner.
module l15_port_arbiter
  import core_pkg::*;
#(
  parameter int unsigned MEM_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [4:0]  fe_l15_rqtype,
  input  logic [2:0]  fe_l15_size,
  input  logic [31:0] fe_l15_address,
  input  logic [31:0] fe_l15_data,
  input  logic        fe_l15_val,

  input  logic [4:0]  mem_l15_rqtype,
  input  logic [2:0]  mem_l15_size,
  input  logic [31:0] mem_l15_address,
  input  logic [31:0] mem_l15_data,
  input  logic        mem_l15_val,

  output logic        l15_fe_ack,
  output logic        l15_fe_header_ack,
  output logic        l15_fe_val,
  output logic        l15_mem_ack,
  output logic        l15_mem_header_ack,
  output logic        l15_mem_val,

  output logic [63:0] rsp_data_0,
  output logic [63:0] rsp_data_1,
  output logic [3:0]  rsp_returntype,

  input  logic        fe_l15_req_ack,
  input  logic        mem_l15_req_ack,

  output logic [4:0]  transducer_l15_rqtype,
  output logic [2:0]  transducer_l15_size,
  output logic [31:0] transducer_l15_address,
  output logic [31:0] transducer_l15_data,
  output logic        transducer_l15_val,

  input  logic        l15_transducer_ack,
  input  logic        l15_transducer_header_ack,

  input  logic        l15_transducer_val,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  input  logic [3:0]  l15_transducer_returntype,

  output logic        transducer_l15_req_ack
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  owner_t     r_owner;
  l15_req_t   r_req;

  l15_req_t   w_fe_req;
  l15_req_t   w_mem_req;
  l15_req_t   w_win_req;
  owner_t     w_win_owner;
  logic       w_grant;
  logic       w_owner_is_fe;
  logic       w_owner_req_ack;

  assign w_fe_req  = '{rqtype: fe_l15_rqtype, size: fe_l15_size,
                       address: fe_l15_address, data: fe_l15_data};
  assign w_mem_req = '{rqtype: mem_l15_rqtype, size: mem_l15_size,
                       address: mem_l15_address, data: mem_l15_data};

  assign w_owner_is_fe   = (r_owner == OWN_FE);
  assign w_owner_req_ack = w_owner_is_fe ? fe_l15_req_ack : mem_l15_req_ack;

  l15_req_mux #(
    .MEM_STREAK_MAX(MEM_STREAK_MAX)
  ) u_req_mux (
    .clk       (clk),
    .rst       (rst),
    .i_grant_en(r_state == ST_IDLE),
    .i_fe_val  (fe_l15_val),
    .i_mem_val (mem_l15_val),
    .i_fe_req  (w_fe_req),
    .i_mem_req (w_mem_req),
    .o_grant   (w_grant),
    .o_owner   (w_win_owner),
    .o_req     (w_win_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_FE;
      r_req   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_owner <= w_win_owner;
        r_req   <= w_win_req;
      end
    end
  end

  // Every output is gated by state, so nothing leaks through in IDLE or
  // straight after reset regardless of what the L1.5 side drives.
  always_comb begin
    w_next_state           = r_state;
    transducer_l15_rqtype  = '0;
    transducer_l15_size    = '0;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    transducer_l15_val     = 1'b0;
    transducer_l15_req_ack = 1'b0;
    l15_fe_ack             = 1'b0;
    l15_fe_header_ack      = 1'b0;
    l15_fe_val             = 1'b0;
    l15_mem_ack            = 1'b0;
    l15_mem_header_ack     = 1'b0;
    l15_mem_val            = 1'b0;
    rsp_data_0             = '0;
    rsp_data_1             = '0;
    rsp_returntype         = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        transducer_l15_rqtype  = r_req.rqtype;
        transducer_l15_size    = r_req.size;
        transducer_l15_address = r_req.address;
        transducer_l15_data    = r_req.data;
        transducer_l15_val     = 1'b1;
        l15_fe_ack             = w_owner_is_fe & l15_transducer_ack;
        l15_mem_ack            = !w_owner_is_fe & l15_transducer_ack;
        l15_fe_header_ack      = w_owner_is_fe & l15_transducer_header_ack;
        l15_mem_header_ack     = !w_owner_is_fe & l15_transducer_header_ack;
        if (l15_transducer_ack) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_data_0             = l15_transducer_data_0;
        rsp_data_1             = l15_transducer_data_1;
        rsp_returntype         = l15_transducer_returntype;
        l15_fe_val             = w_owner_is_fe & l15_transducer_val;
        l15_mem_val            = !w_owner_is_fe & l15_transducer_val;
        transducer_l15_req_ack = w_owner_req_ack;
        if (l15_transducer_val && w_owner_req_ack) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l15_port_arbiter.sv
// Directed bench for l15_port_arbiter: a transaction-level model is checked
// against every output each cycle, plus literal expectations per scenario.
module tb_l15_port_arbiter;

  localparam int STREAK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  fe_l15_rqtype = '0;
  logic [2:0]  fe_l15_size = '0;
  logic [31:0] fe_l15_address = '0;
  logic [31:0] fe_l15_data = '0;
  logic        fe_l15_val = 1'b0;
  logic [4:0]  mem_l15_rqtype = '0;
  logic [2:0]  mem_l15_size = '0;
  logic [31:0] mem_l15_address = '0;
  logic [31:0] mem_l15_data = '0;
  logic        mem_l15_val = 1'b0;
  logic        l15_fe_ack, l15_fe_header_ack, l15_fe_val;
  logic        l15_mem_ack, l15_mem_header_ack, l15_mem_val;
  logic [63:0] rsp_data_0, rsp_data_1;
  logic [3:0]  rsp_returntype;
  logic        fe_l15_req_ack = 1'b0;
  logic        mem_l15_req_ack = 1'b0;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [31:0] transducer_l15_address;
  logic [31:0] transducer_l15_data;
  logic        transducer_l15_val;
  logic        l15_transducer_ack = 1'b0;
  logic        l15_transducer_header_ack = 1'b0;
  logic        l15_transducer_val = 1'b0;
  logic [63:0] l15_transducer_data_0 = '0;
  logic [63:0] l15_transducer_data_1 = '0;
  logic [3:0]  l15_transducer_returntype = '0;
  logic        transducer_l15_req_ack;

  always #5 clk = ~clk;

  l15_port_arbiter #(.MEM_STREAK_MAX(STREAK)) dut (
    .clk(clk), .rst(rst),
    .fe_l15_rqtype(fe_l15_rqtype), .fe_l15_size(fe_l15_size),
    .fe_l15_address(fe_l15_address), .fe_l15_data(fe_l15_data), .fe_l15_val(fe_l15_val),
    .mem_l15_rqtype(mem_l15_rqtype), .mem_l15_size(mem_l15_size),
    .mem_l15_address(mem_l15_address), .mem_l15_data(mem_l15_data), .mem_l15_val(mem_l15_val),
    .l15_fe_ack(l15_fe_ack), .l15_fe_header_ack(l15_fe_header_ack), .l15_fe_val(l15_fe_val),
    .l15_mem_ack(l15_mem_ack), .l15_mem_header_ack(l15_mem_header_ack), .l15_mem_val(l15_mem_val),
    .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1), .rsp_returntype(rsp_returntype),
    .fe_l15_req_ack(fe_l15_req_ack), .mem_l15_req_ack(mem_l15_req_ack),
    .transducer_l15_rqtype(transducer_l15_rqtype), .transducer_l15_size(transducer_l15_size),
    .transducer_l15_address(transducer_l15_address), .transducer_l15_data(transducer_l15_data),
    .transducer_l15_val(transducer_l15_val),
    .l15_transducer_ack(l15_transducer_ack), .l15_transducer_header_ack(l15_transducer_header_ack),
    .l15_transducer_val(l15_transducer_val), .l15_transducer_data_0(l15_transducer_data_0),
    .l15_transducer_data_1(l15_transducer_data_1),
    .l15_transducer_returntype(l15_transducer_returntype),
    .transducer_l15_req_ack(transducer_l15_req_ack)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: phase 0 = free, 1 = request offered, 2 = awaiting response.
  int          m_phase = 0;
  bit          m_own_mem = 1'b0;
  int          m_streak = 0;
  logic [4:0]  m_rqtype = '0;
  logic [2:0]  m_size = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_live = 1'b0;
  bit          grants[$];
  logic        m_inreq, m_inrsp, m_rack;

  assign m_inreq = (m_phase == 1);
  assign m_inrsp = (m_phase == 2);
  assign m_rack  = m_inrsp && (m_own_mem ? mem_l15_req_ack : fe_l15_req_ack);

  function automatic bit fe_first(bit fv, bit mv, int s);
    return fv && (!mv || s == STREAK);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_own_mem <= 1'b0; m_streak <= 0; m_live <= 1'b1;
      m_rqtype <= '0; m_size <= '0; m_addr <= '0; m_data <= '0;
    end else begin
      case (m_phase)
        0: if (fe_l15_val || mem_l15_val) begin
          if (fe_first(fe_l15_val, mem_l15_val, m_streak)) begin
            m_own_mem <= 1'b0; m_streak <= 0;
            m_rqtype <= fe_l15_rqtype; m_size <= fe_l15_size;
            m_addr <= fe_l15_address; m_data <= fe_l15_data;
            grants.push_back(1'b0);
          end else begin
            m_own_mem <= 1'b1;
            if (fe_l15_val) m_streak <= (m_streak >= STREAK) ? STREAK : m_streak + 1;
            m_rqtype <= mem_l15_rqtype; m_size <= mem_l15_size;
            m_addr <= mem_l15_address; m_data <= mem_l15_data;
            grants.push_back(1'b1);
          end
          m_phase <= 1;
        end
        1: if (l15_transducer_ack) m_phase <= 2;
        default: if (l15_transducer_val && m_rack) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("t_val",    transducer_l15_val, m_inreq);
      check("t_rqtype", transducer_l15_rqtype, m_inreq ? m_rqtype : 5'd0);
      check("t_size",   transducer_l15_size, m_inreq ? m_size : 3'd0);
      check("t_addr",   transducer_l15_address, m_inreq ? m_addr : 32'd0);
      check("t_data",   transducer_l15_data, m_inreq ? m_data : 32'd0);
      check("fe_ack",   l15_fe_ack, m_inreq && !m_own_mem && l15_transducer_ack);
      check("mem_ack",  l15_mem_ack, m_inreq && m_own_mem && l15_transducer_ack);
      check("fe_hack",  l15_fe_header_ack, m_inreq && !m_own_mem && l15_transducer_header_ack);
      check("mem_hack", l15_mem_header_ack, m_inreq && m_own_mem && l15_transducer_header_ack);
      check("fe_val",   l15_fe_val, m_inrsp && !m_own_mem && l15_transducer_val);
      check("mem_val",  l15_mem_val, m_inrsp && m_own_mem && l15_transducer_val);
      check("rsp0",     rsp_data_0, m_inrsp ? l15_transducer_data_0 : 64'd0);
      check("rsp1",     rsp_data_1, m_inrsp ? l15_transducer_data_1 : 64'd0);
      check("rtype",    rsp_returntype, m_inrsp ? l15_transducer_returntype : 4'd0);
      check("t_rack",   transducer_l15_req_ack, m_rack);
    end
  end

  // Drives one full transaction from the L1.5 side. Entered just after a
  // rising edge; returns just after the completion edge (arbiter now free).
  task automatic run_txn(input bit exp_mem, input logic [31:0] exp_addr, input int ack_delay,
                         input int rack_delay, input bit val_with_ack, input logic [63:0] rsp0,
                         output int waited);
    waited = 0;
    @(negedge clk);
    while (!transducer_l15_val && waited < 20) begin
      cyc();
      @(negedge clk);
      waited++;
    end
    check("req_val_seen", transducer_l15_val, 1'b1);
    check("req_addr", transducer_l15_address, exp_addr);
    repeat (ack_delay) begin
      cyc();
      fe_l15_address = $urandom; fe_l15_data = $urandom;
      mem_l15_address = $urandom; mem_l15_data = $urandom; mem_l15_val = 1'b1;
      @(negedge clk);
      check("req_addr_hold", transducer_l15_address, exp_addr);
      check("ack_quiet", exp_mem ? l15_mem_ack : l15_fe_ack, 1'b0);
    end
    cyc();
    l15_transducer_ack = 1'b1;
    l15_transducer_header_ack = 1'b1;
    if (val_with_ack) begin
      l15_transducer_val = 1'b1;
      l15_transducer_data_0 = 64'hBAD;
      if (exp_mem) mem_l15_req_ack = 1'b1; else fe_l15_req_ack = 1'b1;
    end
    @(negedge clk);
    check("owner_ack", exp_mem ? l15_mem_ack : l15_fe_ack, 1'b1);
    check("other_ack", exp_mem ? l15_fe_ack : l15_mem_ack, 1'b0);
    check("owner_hack", exp_mem ? l15_mem_header_ack : l15_fe_header_ack, 1'b1);
    check("no_val_in_req", exp_mem ? l15_mem_val : l15_fe_val, 1'b0);
    cyc();
    l15_transducer_ack = 1'b0;
    l15_transducer_header_ack = 1'b0;
    l15_transducer_val = 1'b1;
    l15_transducer_data_0 = rsp0;
    l15_transducer_data_1 = ~rsp0;
    l15_transducer_returntype = 4'h2;
    fe_l15_req_ack = 1'b0;
    mem_l15_req_ack = 1'b0;
    repeat (rack_delay) begin
      @(negedge clk);
      check("rack_gated", transducer_l15_req_ack, 1'b0);
      check("owner_val_wait", exp_mem ? l15_mem_val : l15_fe_val, 1'b1);
      cyc();
    end
    if (exp_mem) mem_l15_req_ack = 1'b1; else fe_l15_req_ack = 1'b1;
    @(negedge clk);
    check("owner_val", exp_mem ? l15_mem_val : l15_fe_val, 1'b1);
    check("other_val", exp_mem ? l15_fe_val : l15_mem_val, 1'b0);
    check("rsp_data_0", rsp_data_0, rsp0);
    check("t_rack_done", transducer_l15_req_ack, 1'b1);
    cyc();
    l15_transducer_val = 1'b0;
    l15_transducer_data_0 = '0;
    l15_transducer_data_1 = '0;
    l15_transducer_returntype = '0;
    fe_l15_req_ack = 1'b0;
    mem_l15_req_ack = 1'b0;
  endtask

  initial begin
    int w;
    logic [31:0] t3_addr [6];
    bit          t3_mem [6];
    t3_addr = '{32'h3000, 32'h3001, 32'h3002, 32'h3003, 32'h1000, 32'h3004};
    t3_mem  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset with L1.5 inputs active: every output must stay low.
    rst = 1'b1;
    l15_transducer_ack = 1'b1; l15_transducer_val = 1'b1; fe_l15_req_ack = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    check("rst_t_val", transducer_l15_val, 1'b0);
    check("rst_fe_ack", l15_fe_ack, 1'b0);
    check("rst_fe_val", l15_fe_val, 1'b0);
    check("rst_t_rack", transducer_l15_req_ack, 1'b0);
    check("rst_rsp0", rsp_data_0, 64'd0);
    cyc();
    rst = 1'b0;
    l15_transducer_ack = 1'b0; l15_transducer_val = 1'b0; fe_l15_req_ack = 1'b0;
    cyc();

    // Fetch alone.
    fe_l15_rqtype = 5'h01; fe_l15_size = 3'h3; fe_l15_address = 32'h1000;
    fe_l15_data = 32'h11; fe_l15_val = 1'b1;
    run_txn(1'b0, 32'h1000, 0, 0, 1'b0, 64'hDEAD, w);
    check("t1_latency", w, 1);
    fe_l15_val = 1'b0;
    cyc();

    // Simultaneous requests: mem first, fetch after one bubble.
    fe_l15_address = 32'h1000; fe_l15_val = 1'b1;
    mem_l15_rqtype = 5'h02; mem_l15_size = 3'h2; mem_l15_address = 32'h2000;
    mem_l15_data = 32'h22; mem_l15_val = 1'b1;
    run_txn(1'b1, 32'h2000, 0, 0, 1'b0, 64'h2222, w);
    check("t2_first_latency", w, 1);
    mem_l15_val = 1'b0;
    run_txn(1'b0, 32'h1000, 0, 0, 1'b0, 64'h1111, w);
    check("t2_bubble", w, 1);
    fe_l15_val = 1'b0;
    cyc();

    // Fetch waits behind a mem stream: starvation guard kicks in after 4.
    grants.delete();
    fe_l15_address = 32'h1000; fe_l15_val = 1'b1;
    mem_l15_address = 32'h3000; mem_l15_val = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_txn(t3_mem[i], t3_addr[i], 0, 0, 1'b0, 64'h3000 + 64'(i), w);
      if (t3_mem[i]) begin
        mem_l15_address = mem_l15_address + 32'h1;
        if (mem_l15_address == 32'h3005) mem_l15_val = 1'b0;
      end else begin
        fe_l15_val = 1'b0;
      end
    end
    check("t3_grant_count", grants.size(), 6);
    for (int i = 0; i < 6; i++) check("t3_model_grant", grants[i], t3_mem[i]);
    cyc();

    // L1.5 stalls ack 10 cycles while inputs churn; ack and val arrive together.
    fe_l15_rqtype = 5'h04; fe_l15_address = 32'h4000; fe_l15_data = 32'h44; fe_l15_val = 1'b1;
    run_txn(1'b0, 32'h4000, 10, 0, 1'b1, 64'h4444, w);
    fe_l15_val = 1'b0; mem_l15_val = 1'b0;
    cyc();

    // Stray response while idle is dropped.
    l15_transducer_val = 1'b1; l15_transducer_data_0 = 64'hFACE; fe_l15_req_ack = 1'b1;
    @(negedge clk);
    check("idle_drop_rack", transducer_l15_req_ack, 1'b0);
    check("idle_drop_val", l15_fe_val, 1'b0);
    cyc();
    l15_transducer_val = 1'b0; l15_transducer_data_0 = '0; fe_l15_req_ack = 1'b0;

    // Mem owner holds req_ack low for 3 cycles of valid response.
    mem_l15_address = 32'h5000; mem_l15_val = 1'b1;
    run_txn(1'b1, 32'h5000, 0, 3, 1'b0, 64'h5555, w);
    mem_l15_val = 1'b0;
    cyc();

    // Reset during the response phase abandons the transaction.
    fe_l15_address = 32'h6000; fe_l15_val = 1'b1;
    w = 0;
    @(negedge clk);
    while (!transducer_l15_val && w < 20) begin cyc(); @(negedge clk); w++; end
    check("t6_req_val", transducer_l15_val, 1'b1);
    cyc();
    l15_transducer_ack = 1'b1;
    cyc();
    l15_transducer_ack = 1'b0;
    fe_l15_val = 1'b0;
    rst = 1'b1;
    l15_transducer_val = 1'b1; l15_transducer_data_0 = 64'h6666;
    @(negedge clk);
    check("t6_pre_rst_val", l15_fe_val, 1'b1);
    cyc();
    rst = 1'b0;
    fe_l15_req_ack = 1'b1;
    @(negedge clk);
    check("t6_t_val", transducer_l15_val, 1'b0);
    check("t6_fe_val", l15_fe_val, 1'b0);
    check("t6_rack", transducer_l15_req_ack, 1'b0);
    check("t6_rsp0", rsp_data_0, 64'd0);
    check("t6_model_streak", m_streak, 0);
    cyc();
    @(negedge clk);
    check("t6_late_val", l15_fe_val, 1'b0);
    cyc();
    l15_transducer_val = 1'b0; l15_transducer_data_0 = '0; fe_l15_req_ack = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
